// File: rtl/ld_scalar_mult_ctrl.sv
// ld_scalar_mult_ctrl: left-to-right double-and-add sequencer for Lopez-Dahab
// scalar multiplication Q = k*P. It owns the scalar scan, the Q accumulator and
// the point-at-infinity flag. All field arithmetic is delegated to an external
// point unit through a registered request / single-cycle acknowledge handshake.
module ld_scalar_mult_ctrl #(
  parameter int N = 3,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [K-1:0] k,
  input  logic [N-1:0] Px,
  input  logic [N-1:0] Py,
  input  logic [N-1:0] Pz,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Qx,
  output logic [N-1:0] Qy,
  output logic [N-1:0] Qz,
  output logic         q_inf,
  output logic         op_req,
  output logic         op_dbl,
  output logic [N-1:0] opA_x,
  output logic [N-1:0] opA_y,
  output logic [N-1:0] opA_z,
  output logic [N-1:0] opB_x,
  output logic [N-1:0] opB_y,
  output logic [N-1:0] opB_z,
  input  logic         op_ack,
  input  logic [N-1:0] res_x,
  input  logic [N-1:0] res_y,
  input  logic [N-1:0] res_z
);

  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] TOP_INDEX = IW'(K - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DBL,
    S_ADD,
    S_DONE
  } state_t;

  state_t        state;
  logic [K-1:0]  kr;
  logic [N-1:0]  pr_x, pr_y, pr_z;
  logic [N-1:0]  q_x, q_y, q_z;
  logic [IW-1:0] idx;

  // Q doubles as operand A and latched P as operand B, so the operands are
  // registered and cannot move while a request is outstanding.
  assign Qx    = q_x;
  assign Qy    = q_y;
  assign Qz    = q_z;
  assign opA_x = q_x;
  assign opA_y = q_y;
  assign opA_z = q_z;
  assign opB_x = pr_x;
  assign opB_y = pr_y;
  assign opB_z = pr_z;

  // Sequencer: scalar scan, accumulator update and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      kr     <= '0;
      pr_x   <= '0;
      pr_y   <= '0;
      pr_z   <= '0;
      q_x    <= '0;
      q_y    <= '0;
      q_z    <= '0;
      idx    <= '0;
      q_inf  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      op_req <= 1'b0;
      op_dbl <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            kr    <= k;
            pr_x  <= Px;
            pr_y  <= Py;
            pr_z  <= Pz;
            idx   <= TOP_INDEX;
            q_inf <= 1'b1;
            q_x   <= '0;
            q_y   <= '0;
            q_z   <= '0;
            busy  <= 1'b1;
            state <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (q_inf) begin
            // Leading zeros cost nothing: Q stays at infinity until the first
            // set bit, which loads P directly instead of doubling infinity.
            if (kr[idx]) begin
              q_x   <= pr_x;
              q_y   <= pr_y;
              q_z   <= pr_z;
              q_inf <= 1'b0;
            end
            if (idx == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx <= idx - IW'(1);
            end
          end else begin
            op_req <= 1'b1;
            op_dbl <= 1'b1;
            state  <= S_DBL;
          end
        end

        S_DBL: begin
          if (op_req && op_ack) begin
            q_x <= res_x;
            q_y <= res_y;
            q_z <= res_z;
            if (kr[idx]) begin
              // Keep the request line up and switch straight to the addition.
              op_dbl <= 1'b0;
              state  <= S_ADD;
            end else begin
              op_req <= 1'b0;
              op_dbl <= 1'b0;
              if (idx == '0) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                idx   <= idx - IW'(1);
                state <= S_SCAN;
              end
            end
          end
        end

        S_ADD: begin
          if (op_req && op_ack) begin
            q_x    <= res_x;
            q_y    <= res_y;
            q_z    <= res_z;
            op_req <= 1'b0;
            if (idx == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx   <= idx - IW'(1);
              state <= S_SCAN;
            end
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy   <= 1'b0;
          op_req <= 1'b0;
          op_dbl <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ld_scalar_mult_ctrl.sv
// tb_ld_scalar_mult_ctrl: directed and randomized commands against a point-unit
// stand-in whose doubling is 2*A and whose addition is A+B per coordinate modulo
// 2^N. With that unit the left-to-right schedule must end at Q = k*P coordinate
// by coordinate, which gives a reference independent of the controller's steps.
module tb_ld_scalar_mult_ctrl;

  localparam int N = 8;
  localparam int K = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [K-1:0] k;
  logic [N-1:0] Px, Py, Pz;
  logic         busy, done, q_inf, op_req, op_dbl, op_ack;
  logic [N-1:0] Qx, Qy, Qz;
  logic [N-1:0] opA_x, opA_y, opA_z, opB_x, opB_y, opB_z;
  logic [N-1:0] res_x, res_y, res_z;

  int checks   = 0;
  int failures = 0;

  ld_scalar_mult_ctrl #(.N(N), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k(k),
    .Px(Px), .Py(Py), .Pz(Pz),
    .busy(busy), .done(done),
    .Qx(Qx), .Qy(Qy), .Qz(Qz), .q_inf(q_inf),
    .op_req(op_req), .op_dbl(op_dbl),
    .opA_x(opA_x), .opA_y(opA_y), .opA_z(opA_z),
    .opB_x(opB_x), .opB_y(opB_y), .opB_z(opB_z),
    .op_ack(op_ack), .res_x(res_x), .res_y(res_y), .res_z(res_z)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiple of a point under the linear stand-in unit.
  function automatic logic [3*N-1:0] scale(input int mult, input logic [N-1:0] x,
                                           input logic [N-1:0] y, input logic [N-1:0] z);
    logic [31:0] a, b, c;
    a = mult * x;
    b = mult * y;
    c = mult * z;
    return {a[N-1:0], b[N-1:0], c[N-1:0]};
  endfunction

  // Result the stand-in unit returns for a request.
  function automatic logic [3*N-1:0] unit_result(input logic dbl, input logic [3*N-1:0] a,
                                                 input logic [3*N-1:0] b);
    logic [N-1:0] rx, ry, rz;
    if (dbl) begin
      rx = a[3*N-1:2*N] << 1;
      ry = a[2*N-1:N] << 1;
      rz = a[N-1:0] << 1;
    end else begin
      rx = a[3*N-1:2*N] + b[3*N-1:2*N];
      ry = a[2*N-1:N] + b[2*N-1:N];
      rz = a[N-1:0] + b[N-1:0];
    end
    return {rx, ry, rz};
  endfunction

  // Busy length: K scan steps, one cycle per op, op waits, plus the DONE cycle.
  function automatic int expected_busy(input logic [K-1:0] kv, input int w);
    int m, pop;
    m = -1;
    pop = 0;
    for (int b = 0; b < K; b++) begin
      if (kv[b]) begin
        m = b;
        pop++;
      end
    end
    if (pop == 0) return K + 1;
    return K + m + (pop - 1) + 1 + w * (m + pop - 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full command: start, serve requests after w wait cycles, check the schedule.
  // disturb re-pulses start with other inputs while busy and acks while op_req is low.
  task automatic applyStimulus(input logic [K-1:0] kv, input logic [N-1:0] px,
                               input logic [N-1:0] py, input logic [N-1:0] pz,
                               input int w, input bit disturb);
    bit exp_ops[$];
    int m, pop, mult, age, busy_cnt, ops_seen;
    bit new_req, finished;
    logic rec_dbl;
    logic [3*N-1:0] rec_a, exp_q, p_all;

    m = -1;
    pop = 0;
    for (int b = 0; b < K; b++) begin
      if (kv[b]) begin
        m = b;
        pop++;
      end
    end
    exp_ops = {};
    for (int b = m - 1; b >= 0; b--) begin
      exp_ops.push_back(1'b1);
      if (kv[b]) exp_ops.push_back(1'b0);
    end
    exp_q    = scale(int'(kv), px, py, pz);
    p_all    = {px, py, pz};
    mult     = 1;
    age      = 0;
    busy_cnt = 0;
    ops_seen = 0;
    new_req  = 1'b1;
    finished = 1'b0;
    rec_dbl  = 1'b0;
    rec_a    = '0;

    k = kv; Px = px; Py = py; Pz = pz;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (disturb) begin
      k = ~kv; Px = ~px; Py = ~py; Pz = ~pz;
    end

    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      op_ack = 1'b0;
      start  = 1'b0;
      if (busy) busy_cnt++;
      if (op_req) begin
        checkOutput("never_inf", q_inf, 1'b0);
        if (new_req) begin
          new_req = 1'b0;
          age     = 0;
          ops_seen++;
          rec_dbl = op_dbl;
          rec_a   = {opA_x, opA_y, opA_z};
          checkOutput("opA_value", rec_a, scale(mult, px, py, pz));
          checkOutput("opB_value", {opB_x, opB_y, opB_z}, p_all);
          if (exp_ops.size() > 0) begin
            checkOutput("op_kind", op_dbl, exp_ops[0]);
            mult = exp_ops[0] ? mult * 2 : mult + 1;
            void'(exp_ops.pop_front());
          end
        end else begin
          checkOutput("op_hold", {op_dbl, opA_x, opA_y, opA_z, opB_x, opB_y, opB_z},
                      {rec_dbl, rec_a, p_all});
          age++;
        end
        if (age == w) begin
          op_ack = 1'b1;
          {res_x, res_y, res_z} = unit_result(rec_dbl, rec_a, {opB_x, opB_y, opB_z});
          new_req = 1'b1;
        end
      end else if (disturb) begin
        op_ack = 1'b1;
        res_x = N'($urandom);
        res_y = N'($urandom);
        res_z = N'($urandom);
      end
      if (disturb && cyc == 1) start = 1'b1;
      if (done) begin
        finished = 1'b1;
        checkOutput("busy_at_done", busy, 1'b1);
        checkOutput("q_result", {Qx, Qy, Qz}, exp_q);
        checkOutput("q_inf_result", q_inf, (kv == '0));
      end else begin
        @(negedge clk);
      end
    end

    checkOutput("completed", finished, 1'b1);
    checkOutput("busy_cycles", busy_cnt, expected_busy(kv, w));
    checkOutput("op_count", ops_seen, (m < 0) ? 0 : (m + pop - 1));

    @(negedge clk);
    op_ack = 1'b0;
    start  = 1'b0;
    checkOutput("idle_after_done", {busy, done, op_req}, 3'b000);
    checkOutput("q_hold", {q_inf, Qx, Qy, Qz}, {(kv == '0), exp_q});
  endtask

  // Linear sequence of directed steps followed by a randomized batch.
  initial begin
    logic [K-1:0] rk;
    rst_n = 1'b0; start = 1'b0; k = '0;
    Px = '0; Py = '0; Pz = '0;
    op_ack = 1'b0; res_x = '0; res_y = '0; res_z = '0;

    #12;
    checkOutput("reset_state", {busy, done, op_req, op_dbl, q_inf, Qx, Qy, Qz},
                {4'b0000, 1'b1, {3*N{1'b0}}});
    @(negedge clk);
    rst_n = 1'b1;

    // Acks while idle must not disturb anything.
    for (int c = 0; c < 3; c++) begin
      op_ack = 1'b1;
      res_x = 8'h5a; res_y = 8'ha5; res_z = 8'h3c;
      @(negedge clk);
      checkOutput("idle_ack_ignored", {busy, op_req, q_inf, Qx, Qy, Qz},
                  {3'b001, {3*N{1'b0}}});
    end
    op_ack = 1'b0;

    $display("[TB] k=0011 zero-wait");
    applyStimulus(4'b0011, 8'd6, 8'd1, 8'd1, 0, 1'b0);
    $display("[TB] k=0 no operations");
    applyStimulus(4'b0000, 8'd9, 8'd4, 8'd2, 0, 1'b0);
    $display("[TB] k=1000 late ack");
    applyStimulus(4'b1000, 8'd3, 8'd7, 8'd1, 3, 1'b0);
    $display("[TB] restart while busy and stray acks");
    applyStimulus(4'b0101, 8'd11, 8'd13, 8'd17, 1, 1'b1);
    applyStimulus(4'b1111, 8'd5, 8'd6, 8'd7, 0, 1'b0);
    applyStimulus(4'b0001, 8'd21, 8'd22, 8'd23, 2, 1'b0);

    $display("[TB] randomized commands");
    for (int t = 0; t < 16; t++) begin
      rk = K'($urandom_range(0, (1 << K) - 1));
      applyStimulus(rk, N'($urandom), N'($urandom), N'($urandom),
                    int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
    end

    // Asynchronous reset while a doubling request is outstanding.
    $display("[TB] reset during DBL");
    k = 4'b1000; Px = 8'd1; Py = 8'd2; Pz = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && !op_req; c++) @(negedge clk);
    checkOutput("reach_dbl", {op_req, op_dbl}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs", {op_req, busy, done, q_inf}, 4'b0001);
    checkOutput("async_reset_q", {Qx, Qy, Qz}, {3*N{1'b0}});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_after_reset", {busy, op_req}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
